// File: rtl/alu_pkg.sv
// Shared ALU types: word width, word type and the condition-flag bundle.
package alu_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef struct packed {
    logic cout;
    logic ovf;
    logic zero;
    logic neg;
  } alu_flags_t;

endpackage

// File: rtl/cla32.sv
// 32-bit carry-lookahead adder from eight 4-bit lookahead groups; purely combinational.
// Exposes the carry into bit 31 so the caller can form signed overflow.
module cla32
  import alu_pkg::*;
(
  input  word_t x,
  input  word_t y,
  input  logic  cin,
  output word_t sum,
  output logic  cout,
  output logic  c31
);

  word_t      p;
  word_t      g;
  logic [3:0] pk;
  logic [3:0] gk;
  logic [3:0] cg;
  logic       gc;
  logic       grp_g;
  logic       grp_p;

  assign p = x ^ y;
  assign g = x & y;

  // Full lookahead inside each group; group carries chain group to group.
  always_comb begin
    sum   = '0;
    c31   = 1'b0;
    pk    = '0;
    gk    = '0;
    cg    = '0;
    grp_g = 1'b0;
    grp_p = 1'b0;
    gc    = cin;
    for (int k = 0; k < 8; k++) begin
      pk    = p[4*k +: 4];
      gk    = g[4*k +: 4];
      cg[0] = gc;
      cg[1] = gk[0] | (pk[0] & gc);
      cg[2] = gk[1] | (pk[1] & gk[0]) | (pk[1] & pk[0] & gc);
      cg[3] = gk[2] | (pk[2] & gk[1]) | (pk[2] & pk[1] & gk[0])
            | (pk[2] & pk[1] & pk[0] & gc);
      grp_g = gk[3] | (pk[3] & gk[2]) | (pk[3] & pk[2] & gk[1])
            | (pk[3] & pk[2] & pk[1] & gk[0]);
      grp_p = &pk;
      sum[4*k +: 4] = pk ^ cg;
      if (k == 7) c31 = cg[3];
      gc = grp_g | (grp_p & gc);
    end
    cout = gc;
  end

endmodule

// File: rtl/add_sub32.sv
// Registered add/subtract with cout/ovf/zero/neg flags; latency 1 cycle.
// No backpressure: one operation accepted per cycle whenever in_valid is high.
module add_sub32
  import alu_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  word_t      b_x;
  word_t      sum;
  logic       add_cout;
  logic       add_c31;
  alu_flags_t flags_nxt;
  alu_flags_t flags_q;

  // Subtraction is a + ~b + 1: invert b and feed sub in as the carry.
  assign b_x = b ^ {WIDTH{sub}};

  cla32 u_cla32 (
    .x    (a),
    .y    (b_x),
    .cin  (sub),
    .sum  (sum),
    .cout (add_cout),
    .c31  (add_c31)
  );

  always_comb begin
    flags_nxt      = '0;
    flags_nxt.cout = add_cout;
    flags_nxt.ovf  = add_cout ^ add_c31;
    flags_nxt.zero = (sum == '0);
    flags_nxt.neg  = sum[WIDTH-1];
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      out_valid <= 1'b0;
      s         <= '0;
      flags_q   <= '{cout: 1'b0, ovf: 1'b0, zero: 1'b1, neg: 1'b0};
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        s       <= sum;
        flags_q <= flags_nxt;
      end
    end
  end

  assign cout = flags_q.cout;
  assign ovf  = flags_q.ovf;
  assign zero = flags_q.zero;
  assign neg  = flags_q.neg;

endmodule

// File: tb/tb_add_sub32.sv
// Bench for add_sub32: directed literal vectors plus an arithmetic reference model checked every cycle.
module tb_add_sub32;

  logic        clock;
  logic        resetn;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic        sub;
  logic        out_valid;
  logic [31:0] s;
  logic        cout;
  logic        ovf;
  logic        zero;
  logic        neg;

  int n_chk  = 0;
  int n_pass = 0;
  logic chk_en = 1'b0;

  add_sub32 #(.WIDTH(32)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .s         (s),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero),
    .neg       (neg)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: plain 64-bit unsigned and signed arithmetic. Returns {ovf, cout, s}.
  function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic op_sub);
    longint ux, uy, sx, sy, ur, sr;
    logic   c, v;
    logic [31:0] r32;
    ux = x;
    uy = y;
    sx = $signed(x);
    sy = $signed(y);
    if (op_sub) begin
      ur = ux - uy;
      c  = (ux >= uy);
      sr = sx - sy;
    end else begin
      ur = ux + uy;
      c  = (ur > 64'sh0000_0000_FFFF_FFFF);
      sr = sx + sy;
    end
    v   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    r32 = ur[31:0];
    return {v, c, r32};
  endfunction

  logic [33:0] m_res;
  logic        m_vld;

  always @(posedge clock) begin
    if (!resetn) begin
      m_vld <= 1'b0;
      m_res <= '0;
    end else begin
      m_vld <= in_valid;
      if (in_valid) m_res <= model(a, b, sub);
    end
  end

  task automatic check(input string nm, input logic [36:0] got, input logic [36:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got {vld,s,cout,ovf,zero,neg}=%h required %h", nm, got, exp);
  endtask

  function automatic logic [36:0] actual();
    return {out_valid, s, cout, ovf, zero, neg};
  endfunction

  always @(posedge clock) begin
    #1;
    if (chk_en)
      check("model", actual(),
            {m_vld, m_res[31:0], m_res[32], m_res[33], (m_res[31:0] == 32'd0), m_res[31]});
  end

  task automatic op(input string nm, input logic [31:0] ta, input logic [31:0] tb_v,
                    input logic ts, input logic [31:0] es, input logic ec,
                    input logic eo, input logic ez, input logic en);
    @(negedge clock);
    a = ta; b = tb_v; sub = ts; in_valid = 1'b1;
    @(posedge clock); #1;
    check(nm, actual(), {1'b1, es, ec, eo, ez, en});
  endtask

  task automatic idle(input string nm, input logic [31:0] ta, input logic [31:0] tb_v,
                      input logic [31:0] es, input logic ec, input logic eo,
                      input logic ez, input logic en);
    @(negedge clock);
    a = ta; b = tb_v; sub = ~sub; in_valid = 1'b0;
    @(posedge clock); #1;
    check(nm, actual(), {1'b0, es, ec, eo, ez, en});
  endtask

  initial begin
    resetn = 1'b0; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    resetn = 1'b1;
    chk_en = 1'b1;
    @(posedge clock); #1;
    check("reset", actual(), {1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0});

    // Back-to-back directed vectors: in_valid stays high throughout.
    op("add_3_4",     32'd3,         32'd4,         1'b0, 32'd7,         1'b0, 1'b0, 1'b0, 1'b0);
    op("sub_borrow",  32'd3,         32'd4,         1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1);
    op("sub_equal",   32'd5,         32'd5,         1'b1, 32'd0,         1'b1, 1'b0, 1'b1, 1'b0);
    op("add_ovf",     32'h7FFF_FFFF, 32'd1,         1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
    op("add_wrap",    32'hFFFF_FFFF, 32'd1,         1'b0, 32'd0,         1'b1, 1'b0, 1'b1, 1'b0);
    op("add_mixed",   32'h1234_5678, 32'h8765_4321, 1'b0, 32'h9999_9999, 1'b0, 1'b0, 1'b0, 1'b1);
    op("sub_ovf",     32'h8000_0000, 32'd1,         1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0);

    idle("hold_1", 32'hDEAD_BEEF, 32'h1234_0000, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0);
    idle("hold_2", 32'h0000_0001, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0);

    // Reset on the same edge as a valid operation wins and suppresses out_valid.
    op("pre_reset", 32'd1, 32'd2, 1'b0, 32'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    resetn = 1'b0; in_valid = 1'b1; a = 32'd10; b = 32'd20; sub = 1'b0;
    @(posedge clock); #1;
    check("reset_mid", actual(), {1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0});
    @(negedge clock);
    resetn = 1'b1; in_valid = 1'b0;
    @(posedge clock); #1;
    check("reset_after", actual(), {1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0});

    // Random traffic with occasional corner operands, checked by the model.
    for (int i = 0; i < 10000; i++) begin
      @(negedge clock);
      in_valid = ($urandom_range(3) != 0);
      sub      = $urandom_range(1);
      case ($urandom_range(7))
        0:       a = 32'h8000_0000;
        1:       a = 32'hFFFF_FFFF;
        default: a = $urandom;
      endcase
      case ($urandom_range(7))
        0:       b = 32'h7FFF_FFFF;
        1:       b = a;
        default: b = $urandom;
      endcase
    end
    @(negedge clock);
    in_valid = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
